// File: rtl/rf_ckpt_pkg.sv
// Shared state type and sizing helpers for the register-file checkpoint sequencer.
package rf_ckpt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SAVE,
      RESTORE,
      DONE
   } ckpt_state_t;

   // Register-file port addresses are always 5 bits wide, even for the 16-entry file.
   localparam int unsigned RF_PORT_AW = 5;

   function automatic int unsigned addr_width(input int unsigned rv32e);
      return (rv32e != 0) ? 4 : 5;
   endfunction

   function automatic int unsigned num_words(input int unsigned rv32e);
      return 1 << addr_width(rv32e);
   endfunction

endpackage

// File: rtl/rf_ckpt_ctrl_rf_port_mux.sv
// Selects whether the core or the save/restore engine drives the register-file ports.
module rf_port_mux
   import rf_ckpt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  ckpt_state_t                state,
   input  logic [RF_PORT_AW-1:0]      cnt,
   input  logic [RF_PORT_AW-1:0]      core_raddr,
   input  logic [RF_PORT_AW-1:0]      core_waddr,
   input  logic [DATA_WIDTH-1:0]      core_wdata,
   input  logic                       core_we,
   input  logic                       rstr_valid,
   input  logic [DATA_WIDTH-1:0]      rstr_data,
   output logic [RF_PORT_AW-1:0]      rf_raddr,
   output logic [RF_PORT_AW-1:0]      rf_waddr,
   output logic [DATA_WIDTH-1:0]      rf_wdata,
   output logic                       rf_we
);

   // Core writes reach the file only in IDLE; DONE drives no write at all.
   always_comb begin
      rf_raddr = core_raddr;
      rf_waddr = core_waddr;
      rf_wdata = core_wdata;
      rf_we    = 1'b0;
      case (state)
         IDLE:    rf_we = core_we;
         SAVE:    rf_raddr = cnt;
         RESTORE: begin
            rf_waddr = cnt;
            rf_wdata = rstr_data;
            rf_we    = rstr_valid;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rf_ckpt_ctrl.sv
// Checkpoint/restore sequencer for the flip-flop register file.
// Optional parity side-band is enabled by defining RF_CKPT_PARITY_EN.
module rf_ckpt_ctrl
   import rf_ckpt_pkg::*;
#(
   parameter int unsigned RV32E      = 0,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  save_req_i,
   input  logic                  restore_req_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic [4:0]            core_raddr_i,
   output logic [DATA_WIDTH-1:0] core_rdata_o,
   input  logic [4:0]            core_waddr_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   input  logic                  core_we_i,
   output logic                  core_stall_o,
   output logic [4:0]            rf_raddr_o,
   input  logic [DATA_WIDTH-1:0] rf_rdata_i,
   output logic [4:0]            rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  rf_we_o,
   output logic                  ckpt_valid_o,
   input  logic                  ckpt_ready_i,
   output logic [DATA_WIDTH-1:0] ckpt_data_o,
   input  logic                  rstr_valid_i,
   output logic                  rstr_ready_o,
   input  logic [DATA_WIDTH-1:0] rstr_data_i
`ifdef RF_CKPT_PARITY_EN
   ,
   output logic                  ckpt_par_o,
   input  logic                  rstr_par_i,
   output logic                  par_err_o
`endif
);

   localparam int unsigned   AW       = addr_width(RV32E);
   localparam logic [AW-1:0] LAST_IDX = AW'(num_words(RV32E) - 1);
   localparam logic [AW-1:0] FIRST_IDX = AW'(1);

   ckpt_state_t             state;
   logic [AW-1:0]           cnt;
   logic [RF_PORT_AW-1:0]   cnt_ext;

   assign cnt_ext      = RF_PORT_AW'(cnt);
   assign core_stall_o = busy_o;
   assign core_rdata_o = rf_rdata_i;
   assign ckpt_data_o  = rf_rdata_i;

   // Flags are registered alongside the state so each one changes on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= FIRST_IDX;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         ckpt_valid_o <= 1'b0;
         rstr_ready_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (save_req_i) begin
                  state        <= SAVE;
                  busy_o       <= 1'b1;
                  ckpt_valid_o <= 1'b1;
               end else if (restore_req_i) begin
                  state        <= RESTORE;
                  busy_o       <= 1'b1;
                  rstr_ready_o <= 1'b1;
               end
            end
            SAVE: begin
               if (ckpt_valid_o && ckpt_ready_i) begin
                  cnt <= cnt + AW'(1);
                  if (cnt == LAST_IDX) begin
                     state        <= DONE;
                     busy_o       <= 1'b0;
                     ckpt_valid_o <= 1'b0;
                     done_o       <= 1'b1;
                  end
               end
            end
            RESTORE: begin
               if (rstr_valid_i) begin
                  cnt <= cnt + AW'(1);
                  if (cnt == LAST_IDX) begin
                     state        <= DONE;
                     busy_o       <= 1'b0;
                     rstr_ready_o <= 1'b0;
                     done_o       <= 1'b1;
                  end
               end
            end
            DONE: begin
               cnt   <= FIRST_IDX;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   rf_port_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .state      (state),
      .cnt        (cnt_ext),
      .core_raddr (core_raddr_i),
      .core_waddr (core_waddr_i),
      .core_wdata (core_wdata_i),
      .core_we    (core_we_i),
      .rstr_valid (rstr_valid_i),
      .rstr_data  (rstr_data_i),
      .rf_raddr   (rf_raddr_o),
      .rf_waddr   (rf_waddr_o),
      .rf_wdata   (rf_wdata_o),
      .rf_we      (rf_we_o)
   );

`ifdef RF_CKPT_PARITY_EN
   logic req_accept;

   assign ckpt_par_o = ^ckpt_data_o;
   assign req_accept = (state == IDLE) && (save_req_i || restore_req_i);

   // Sticky error: a bad beat is still written, the flag just records that it happened.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_o <= 1'b0;
      end else if (req_accept) begin
         par_err_o <= 1'b0;
      end else if ((state == RESTORE) && rstr_valid_i && ((^rstr_data_i) != rstr_par_i)) begin
         par_err_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rf_ckpt_ctrl.sv
// Randomized bench for rf_ckpt_ctrl against an array/queue model of the register file contents.
module tb_rf_ckpt_ctrl;

   logic        clk;
   logic        rst_n;
   logic        save_req, restore_req, busy, done, stall;
   logic [4:0]  core_raddr, core_waddr, rf_raddr, rf_waddr;
   logic [31:0] core_rdata, core_wdata, rf_rdata, rf_wdata, ckpt_data, rstr_data;
   logic        core_we, rf_we, ckpt_valid, ckpt_ready, rstr_valid, rstr_ready;

   logic        e_save_req, e_busy, e_done, e_stall, e_rf_we, e_ckpt_valid, e_rstr_ready;
   logic [4:0]  e_rf_raddr, e_rf_waddr, e_core_waddr;
   logic [31:0] e_core_rdata, e_rf_rdata, e_rf_wdata, e_ckpt_data, e_core_wdata;
   logic        e_core_we;

`ifdef RF_CKPT_PARITY_EN
   logic ckpt_par, rstr_par, par_err;
   logic e_ckpt_par, e_par_err;
`endif

   logic [31:0] rf_mem  [32];
   logic [31:0] e_mem   [16];
   logic [31:0] exp_mem [32];
   int errors = 0;
   int checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register files the controller sits in front of.
   assign rf_rdata   = (rf_raddr == 5'd0) ? 32'd0 : rf_mem[rf_raddr];
   assign e_rf_rdata = (e_rf_raddr[3:0] == 4'd0) ? 32'd0 : e_mem[e_rf_raddr[3:0]];
   always @(posedge clk) begin
      if (rf_we && rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
      if (e_rf_we && e_rf_waddr[3:0] != 4'd0) e_mem[e_rf_waddr[3:0]] <= e_rf_wdata;
   end

   rf_ckpt_ctrl #(.RV32E(0), .DATA_WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .save_req_i(save_req), .restore_req_i(restore_req),
      .busy_o(busy), .done_o(done), .core_raddr_i(core_raddr), .core_rdata_o(core_rdata),
      .core_waddr_i(core_waddr), .core_wdata_i(core_wdata), .core_we_i(core_we),
      .core_stall_o(stall), .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
      .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we),
      .ckpt_valid_o(ckpt_valid), .ckpt_ready_i(ckpt_ready), .ckpt_data_o(ckpt_data),
      .rstr_valid_i(rstr_valid), .rstr_ready_o(rstr_ready), .rstr_data_i(rstr_data)
`ifdef RF_CKPT_PARITY_EN
      , .ckpt_par_o(ckpt_par), .rstr_par_i(rstr_par), .par_err_o(par_err)
`endif
   );

   rf_ckpt_ctrl #(.RV32E(1), .DATA_WIDTH(32)) u_dut_e (
      .clk(clk), .rst_n(rst_n), .save_req_i(e_save_req), .restore_req_i(1'b0),
      .busy_o(e_busy), .done_o(e_done), .core_raddr_i(5'd0), .core_rdata_o(e_core_rdata),
      .core_waddr_i(e_core_waddr), .core_wdata_i(e_core_wdata), .core_we_i(e_core_we),
      .core_stall_o(e_stall), .rf_raddr_o(e_rf_raddr), .rf_rdata_i(e_rf_rdata),
      .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .rf_we_o(e_rf_we),
      .ckpt_valid_o(e_ckpt_valid), .ckpt_ready_i(1'b1), .ckpt_data_o(e_ckpt_data),
      .rstr_valid_i(1'b0), .rstr_ready_o(e_rstr_ready), .rstr_data_i(32'd0)
`ifdef RF_CKPT_PARITY_EN
      , .ckpt_par_o(e_ckpt_par), .rstr_par_i(1'b0), .par_err_o(e_par_err)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      core_raddr = 5'($urandom_range(1, 31));
      #3;
      checks++;
      if ({busy, done, ckpt_valid, rstr_ready, stall} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, ckpt_valid, rstr_ready, stall});
      end
      checks++;
      if (rf_raddr !== core_raddr) begin
         errors++;
         $display("[TB] FAIL reset_passthru: rf_raddr=%0d want %0d", rf_raddr, core_raddr);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_preload(input logic [31:0] base);
      exp_mem[0] = 32'd0;
      for (int i = 1; i < 32; i++) begin
         core_we = 1'b1;
         core_waddr = 5'(i);
         core_wdata = base + 32'(i);
         #1;
         checks++;
         if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== base + 32'(i)) begin
            errors++;
            $display("[TB] FAIL preload_passthru x%0d: we=%b addr=%0d data=%h", i, rf_we, rf_waddr, rf_wdata);
         end
         exp_mem[i] = base + 32'(i);
         step();
      end
      core_we = 1'b0;
   endtask

   task automatic test_readback();
      for (int i = 0; i < 32; i++) begin
         core_raddr = 5'(i);
         #1;
         checks++;
         if (core_rdata !== exp_mem[i]) begin
            errors++;
            $display("[TB] FAIL readback x%0d: got %h want %h", i, core_rdata, exp_mem[i]);
         end
      end
      step();
   endtask

   // mode 0: ready always high, 1: ready alternates starting low, 2: random ready
   task automatic test_save(input int mode, input int expect_cycles, input bit with_restore);
      logic [31:0] q[$];
      int cyc;
      for (int k = 1; k < 32; k++) q.push_back(exp_mem[k]);
      save_req = 1'b1;
      restore_req = with_restore;
      step();
      save_req = 1'b0;
      restore_req = 1'b0;
`ifdef RF_CKPT_PARITY_EN
      checks++;
      if (par_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL par_err_clear_on_save: got %b want 0", par_err);
      end
`endif
      cyc = 0;
      while (q.size() > 0 && cyc < 200) begin
         case (mode)
            0:       ckpt_ready = 1'b1;
            1:       ckpt_ready = cyc[0];
            default: ckpt_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         checks++;
         if ({busy, stall, ckpt_valid, rstr_ready, done} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL save_flags cyc%0d: got %b want 11100", cyc, {busy, stall, ckpt_valid, rstr_ready, done});
         end
         checks++;
         if (ckpt_data !== q[0]) begin
            errors++;
            $display("[TB] FAIL save_data cyc%0d: got %h want %h", cyc, ckpt_data, q[0]);
         end
`ifdef RF_CKPT_PARITY_EN
         checks++;
         if (ckpt_par !== ^q[0]) begin
            errors++;
            $display("[TB] FAIL save_parity cyc%0d: got %b want %b", cyc, ckpt_par, ^q[0]);
         end
`endif
         if (ckpt_ready) void'(q.pop_front());
         step();
         cyc++;
      end
      ckpt_ready = 1'b0;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("[TB] FAIL save_timeout: %0d words left want 0", q.size());
      end
      if (expect_cycles > 0) begin
         checks++;
         if (cyc != expect_cycles) begin
            errors++;
            $display("[TB] FAIL save_latency: got %0d cycles want %0d", cyc, expect_cycles);
         end
      end
      #1;
      checks++;
      if ({done, busy, ckpt_valid} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL save_done: got %b want 100", {done, busy, ckpt_valid});
      end
      step();
      checks++;
      if ({done, busy, rstr_ready} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL save_after_done: got %b want 000", {done, busy, rstr_ready});
      end
   endtask

   task automatic test_restore(input logic [31:0] base, input int flip_beat, input bit poke_save);
      int idx;
      int cyc;
      restore_req = 1'b1;
      step();
      restore_req = 1'b0;
      idx = 1;
      cyc = 0;
      while (idx < 32 && cyc < 400) begin
         rstr_valid = ($urandom_range(0, 3) != 0);
         rstr_data = base + 32'(idx);
         core_we = 1'b1;
         core_waddr = 5'($urandom_range(1, 31));
         core_wdata = 32'hDEAD0000 | 32'(cyc);
         save_req = poke_save && (cyc == 5);
`ifdef RF_CKPT_PARITY_EN
         rstr_par = (^rstr_data) ^ (flip_beat == idx);
`endif
         #1;
         checks++;
         if ({busy, stall, rstr_ready, ckpt_valid, done} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL restore_flags cyc%0d: got %b want 11100", cyc, {busy, stall, rstr_ready, ckpt_valid, done});
         end
         checks++;
         if (rf_we !== rstr_valid) begin
            errors++;
            $display("[TB] FAIL restore_we cyc%0d: got %b want %b", cyc, rf_we, rstr_valid);
         end
`ifdef RF_CKPT_PARITY_EN
         checks++;
         if (par_err !== (flip_beat > 0 && idx > flip_beat)) begin
            errors++;
            $display("[TB] FAIL restore_par_err cyc%0d: got %b want %b", cyc, par_err, (flip_beat > 0 && idx > flip_beat));
         end
`endif
         if (rstr_valid) begin
            checks++;
            if (rf_waddr !== 5'(idx) || rf_wdata !== base + 32'(idx)) begin
               errors++;
               $display("[TB] FAIL restore_beat x%0d: addr=%0d data=%h want %0d %h", idx, rf_waddr, rf_wdata, idx, base + 32'(idx));
            end
            exp_mem[idx] = base + 32'(idx);
            idx++;
         end
         step();
         cyc++;
      end
      rstr_valid = 1'b0;
      core_we = 1'b0;
      save_req = 1'b0;
      checks++;
      if (idx != 32) begin
         errors++;
         $display("[TB] FAIL restore_timeout: reached x%0d want x32", idx);
      end
      #1;
      checks++;
      if ({done, busy, rstr_ready, rf_we} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL restore_done: got %b want 1000", {done, busy, rstr_ready, rf_we});
      end
      step();
      checks++;
      if ({done, busy, ckpt_valid} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL restore_after_done: got %b want 000", {done, busy, ckpt_valid});
      end
   endtask

   task automatic test_both_requests();
      test_save(2, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({busy, rstr_ready, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL both_req_no_restore: got %b want 000", {busy, rstr_ready, done});
         end
         step();
      end
   endtask

   task automatic test_abort();
      save_req = 1'b1;
      step();
      save_req = 1'b0;
      ckpt_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      ckpt_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, stall, ckpt_valid, done} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL abort_flags: got %b want 0000", {busy, stall, ckpt_valid, done});
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL abort_no_done: got %b want 00", {busy, done});
      end
      test_save(0, 31, 1'b0);
   endtask

   task automatic test_rv32e();
      logic [31:0] q[$];
      int beats;
      int cyc;
      for (int i = 1; i < 16; i++) begin
         e_core_we = 1'b1;
         e_core_waddr = 5'(i);
         e_core_wdata = 32'h200 + 32'(i);
         q.push_back(32'h200 + 32'(i));
         step();
      end
      e_core_we = 1'b0;
      e_save_req = 1'b1;
      step();
      e_save_req = 1'b0;
      beats = 0;
      cyc = 0;
      while (e_done !== 1'b1 && cyc < 100) begin
         if (e_ckpt_valid === 1'b1) begin
            checks++;
            if (q.size() == 0 || e_ckpt_data !== q[0]) begin
               errors++;
               $display("[TB] FAIL rv32e_data beat%0d: got %h want %h", beats, e_ckpt_data, (q.size() > 0) ? q[0] : 32'hx);
            end
            if (q.size() > 0) void'(q.pop_front());
            beats++;
         end
         step();
         cyc++;
      end
      checks++;
      if (beats != 15 || cyc != 15) begin
         errors++;
         $display("[TB] FAIL rv32e_beats: got %0d beats in %0d cycles want 15 in 15", beats, cyc);
      end
      step();
      checks++;
      if ({e_done, e_busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rv32e_after_done: got %b want 00", {e_done, e_busy});
      end
   endtask

`ifdef RF_CKPT_PARITY_EN
   task automatic test_parity();
      test_restore(32'h5A5A0000, 3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (par_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL parity_sticky: got %b want 1", par_err);
         end
         step();
      end
      test_save(0, 31, 1'b0);
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      save_req = 1'b0; restore_req = 1'b0;
      core_raddr = 5'd0; core_waddr = 5'd0; core_wdata = 32'd0; core_we = 1'b0;
      ckpt_ready = 1'b0; rstr_valid = 1'b0; rstr_data = 32'd0;
      e_save_req = 1'b0; e_core_we = 1'b0; e_core_waddr = 5'd0; e_core_wdata = 32'd0;
`ifdef RF_CKPT_PARITY_EN
      rstr_par = 1'b0;
`endif
      test_reset();
      test_preload(32'h100);
      test_save(0, 31, 1'b0);
      test_save(1, 62, 1'b0);
      test_restore(32'hA0000000, 0, 1'b0);
      test_readback();
      test_both_requests();
      test_restore(32'hB0000000, 0, 1'b1);
      test_readback();
      test_abort();
      test_rv32e();
`ifdef RF_CKPT_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
